rra: RTL and testbench
======================

// Module: rra
//
// PURPOSE
// - Round-robin arbiter: grants one of N requesters per clock with rotating priority.
// - The most recently granted requester drops to lowest priority, so no active requester starves.
// - Sits between N bus/resource masters and a single shared resource.
// - Output is a registered one-hot grant vector.
//
// PARAMETERS
// - N  default 4  number of requesters; N >= 2.
//
// PORTS
// - clk     in   1  clock; all state updates on the rising edge.
// - rst     in   1  reset; asynchronous, active-low.
// - req     in   N  request vector; bit i high = requester i wants the resource.
// - granto  out  N  registered grant vector; one-hot or all-zero.
//
// BEHAVIOUR
// - Clock and reset: one clock (clk). Reset rst is asynchronous and active-low.
// - rst low:
//   - granto = 0 immediately, without waiting for a clock edge.
//   - Priority pointer ptr = 0, so requester 0 has highest priority.
//   - req is ignored while rst is low.
// - State:
//   - ptr, clog2(N) bits = index of the highest-priority requester.
//   - granto register, N bits.
// - Each rising edge with rst high:
//   - Search req starting at index ptr, ascending with wrap-around
//     (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
//   - The first set bit k wins: granto <= one-hot(k), ptr <= (k+1) mod N.
//   - If req == 0: granto <= 0 and ptr holds its value.
// - Latency:
//   - req sampled at edge t is reflected in granto after edge t (one-cycle registered latency).
//   - No combinational path from req to granto.
// - Grant persistence:
//   - No lock/hold. Arbitration repeats every cycle.
//   - A requester holding req high receives at most one grant per round while others request.
// - Invariants:
//   - granto is always one-hot or zero.
//   - granto[i] is set only if req[i] was high at the sampling edge.
// - Wrap-around:
//   - Grant to N-1 sets ptr = 0.
//   - Search wraps from N-1 to 0.
// - Single requester: it is granted every cycle; ptr tracks k+1.
// - Request change between edges: only the value at the edge matters; glitches are ignored.
// - Reset mid-operation: granto clears asynchronously and ptr returns to 0.
//   The first grant after rst deassertion follows the fixed order from index 0.
// - Implementation: a double-width (2N) masked priority search, or a mask/unmasked
//   dual priority encoder; either is acceptable.
//
// STRUCTURE
// - Shared package rra_pkg holds:
//   - constant RRA_N_DEFAULT = 4
//   - function clog2 helper
//   - typedef for the one-hot grant vector
// - One sub-module, rra_prio_pick: combinational rotate-priority picker.
//   - Inputs: req[N], ptr.
//   - Outputs: gnt_onehot[N], gnt_idx, any_req.
// - The top level holds only the ptr and granto registers plus reset logic.
//
// TESTING
// 1. rst low, req=4'b1111 toggling -> granto=4'b0000 throughout; stays 0 on the first edge
//    after rst rises only if req=0.
// 2. rst high, req=4'b1111 held -> granto sequence 0001, 0010, 0100, 1000, 0001 on
//    consecutive edges.
// 3. req=4'b0100 held -> granto=0100 every edge; then req=4'b1000 -> granto=1000 on the
//    next edge.
// 4. Last grant 0100 (ptr=3), req=4'b1010 held -> granto 1000, 0010, 1000, 0010
//    (alternation, no starvation).
// 5. req=4'b0000 for 3 edges after a 1000 grant -> granto=0000 with ptr=0 held;
//    then req=4'b0011 -> granto=0001.
// 6. Assert rst low between edges while granto=0010 -> granto=0000 before the next edge;
//    release with req=4'b1111 -> first grant 0001.
// - Run on every cycle: assertion that granto is one-hot or zero, and that
//   granto & ~req_sampled == 0.

Source files
------------

// File: rtl/rra_pkg.sv
// Shared definitions for the round-robin arbiter: default size, clog2 helper, grant type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rra_pkg;

  localparam int RRA_N_DEFAULT = 4;

  // One-hot grant vector at the default requester count.
  typedef logic [RRA_N_DEFAULT-1:0] rra_gnt_t;

  // Ceiling log2 with a floor of 1, so a pointer is never zero bits wide.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rra_prio_pick.sv
// Rotating-priority picker: first set req bit searching upward from ptr with wrap.
// Latency: purely combinational.
// Backpressure: none; the result is consumed by the caller's registers.
//
// Ports:
//   req        in   N   request vector
//   ptr        in   PW  index of the highest-priority requester
//   gnt_onehot out  N   one-hot winner, zero when no request
//   gnt_idx    out  PW  index of the winner (0 when no request)
//   any_req    out  1   at least one request bit set
module rra_prio_pick
  import rra_pkg::*;
#(
  parameter int N  = RRA_N_DEFAULT,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [PW-1:0] gnt_idx,
  output logic          any_req
);

  localparam logic [PW:0] NW = (PW+1)'(N);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  first;
  logic [PW:0]    sum;

  always_comb begin
    // Rotate the request vector so that bit 0 of rot is requester ptr;
    // the lowest set bit of rot is then the winner's offset from ptr.
    dbl   = {req, req} >> ptr;
    rot   = dbl[N-1:0];
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = PW'(i);
    end

    // Map the offset back to an absolute index, modulo N.
    sum = {1'b0, ptr} + {1'b0, first};
    if (sum >= NW) sum = sum - NW;

    any_req    = |req;
    gnt_idx    = any_req ? sum[PW-1:0] : '0;
    gnt_onehot = any_req ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

endmodule

// File: rtl/rra.sv
// Round-robin arbiter: one registered one-hot grant per clock, last winner drops to lowest priority.
// Latency: req sampled at edge t appears on granto after edge t; no req->granto comb path.
// Backpressure: none; arbitration repeats every cycle with no hold or lock.
//
// Ports:
//   clk     in   1  clock
//   rst     in   1  asynchronous active-low reset (clears granto, ptr -> 0)
//   req     in   N  request vector
//   granto  out  N  registered grant, one-hot or zero
module rra
  import rra_pkg::*;
#(
  parameter int N = RRA_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] granto
);

  localparam int            PW   = clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [N-1:0]  gnt_onehot;
  logic [PW-1:0] gnt_idx;
  logic          any_req;

  rra_prio_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req        (req),
    .ptr        (ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any_req    (any_req)
  );

  // Winner's successor becomes highest priority; N-1 wraps to 0.
  assign ptr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr    <= '0;
      granto <= '0;
    end else if (any_req) begin
      ptr    <= ptr_nxt;
      granto <= gnt_onehot;
    end else begin
      // Idle cycle: no grant, priority pointer holds.
      granto <= '0;
    end
  end

endmodule

// File: tb/tb_rra.sv
// Self-checking bench for rra: directed vector table, reset corner sequences,
// and random requests checked against a rotating-priority reference model.
module tb_rra;
  import rra_pkg::*;

  localparam int N = RRA_N_DEFAULT;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  rra_gnt_t     granto;

  int vecs = 0;
  int errs = 0;

  // Reference model state: index that has highest priority next.
  int m_ptr = 0;

  logic [N-1:0] req_smp = '0;

  always #5 clk = ~clk;

  rra #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .granto (granto)
  );

  always @(posedge clk) req_smp <= req;

  // Per-cycle invariants: one-hot-or-zero, and only requesters that asked are granted.
  always @(negedge clk) begin
    vecs++;
    if (!$onehot0(granto) || ((granto & ~req_smp) != '0)) begin
      errs++;
      $display("FAIL invariant: granto=%b req_sampled=%b (need one-hot0 and subset)", granto, req_smp);
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: granto=%b expected %b", nm, act, exp);
    end
  endtask

  // Search from m_ptr upward with wrap; first requester wins and its successor leads next.
  task automatic model_step(input logic [N-1:0] r, output logic [N-1:0] exp);
    exp = '0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (r[k]) begin
        exp[k] = 1'b1;
        m_ptr  = (k + 1) % N;
        break;
      end
    end
  endtask

  task automatic edge_step(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string        nm;
    logic [N-1:0] req;
    logic [N-1:0] exp;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic [N-1:0] mexp;
    logic [N-1:0] r;

    tbl[0]  = '{"rr_all_0",    4'b1111, 4'b0001};
    tbl[1]  = '{"rr_all_1",    4'b1111, 4'b0010};
    tbl[2]  = '{"rr_all_2",    4'b1111, 4'b0100};
    tbl[3]  = '{"rr_all_3",    4'b1111, 4'b1000};
    tbl[4]  = '{"rr_all_wrap", 4'b1111, 4'b0001};
    tbl[5]  = '{"single2_a",   4'b0100, 4'b0100};
    tbl[6]  = '{"single2_b",   4'b0100, 4'b0100};
    tbl[7]  = '{"single3",     4'b1000, 4'b1000};
    tbl[8]  = '{"setup_p3",    4'b0100, 4'b0100};
    tbl[9]  = '{"alt_0",       4'b1010, 4'b1000};
    tbl[10] = '{"alt_1",       4'b1010, 4'b0010};
    tbl[11] = '{"alt_2",       4'b1010, 4'b1000};
    tbl[12] = '{"alt_3",       4'b1010, 4'b0010};
    tbl[13] = '{"setup_g3",    4'b1000, 4'b1000};
    tbl[14] = '{"idle_0",      4'b0000, 4'b0000};
    tbl[15] = '{"idle_1",      4'b0000, 4'b0000};
    tbl[16] = '{"idle_2",      4'b0000, 4'b0000};
    tbl[17] = '{"after_idle",  4'b0011, 4'b0001};

    // Reset is asynchronous: granto is zero before any clock edge.
    rst = 1'b0;
    req = '0;
    #1;
    chk("reset_async", granto, '0);

    // Requests are ignored while reset is held.
    for (int i = 0; i < 4; i++) begin
      edge_step((i % 2 == 0) ? 4'b1111 : 4'b0000);
      chk("reset_hold", granto, '0);
    end

    // Release between edges with no requests: first edge still grants nothing.
    req = '0;
    #2;
    rst = 1'b1;
    m_ptr = 0;
    edge_step(4'b0000);
    model_step(4'b0000, mexp);
    chk("release_idle", granto, '0);

    // Directed sequences from a fresh pointer of 0.
    for (int i = 0; i < 18; i++) begin
      edge_step(tbl[i].req);
      model_step(tbl[i].req, mexp);
      chk(tbl[i].nm, granto, tbl[i].exp);
    end

    // Pointer now at 1: next all-request grant is 0010, then reset it mid-cycle.
    edge_step(4'b1111);
    model_step(4'b1111, mexp);
    chk("pre_reset_grant", granto, 4'b0010);
    #3;
    rst = 1'b0;
    #1;
    chk("reset_mid_async", granto, '0);
    #1;
    req = 4'b1111;
    rst = 1'b1;
    m_ptr = 0;
    edge_step(4'b1111);
    model_step(4'b1111, mexp);
    chk("first_after_reset", granto, 4'b0001);

    // Random traffic against the reference model, with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        #1;
        chk("rand_reset", granto, '0);
        rst = 1'b1;
        m_ptr = 0;
      end
      r = N'($urandom);
      if ($urandom_range(0, 2) == 0) r = r & N'($urandom);
      edge_step(r);
      model_step(r, mexp);
      chk("random", granto, mexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
